mux8lut_out_pipe: RTL and testbench

Configurable output register stage sitting directly downstream of the MUX8LUT wide-function multiplexer in the LUT4AB tile. It takes the four mux results (M_AB, M_AD, M_AH, M_EF), and for each one independently either passes it through combinationally or delays it by one or two registered stages. Registered stages support a shared clock enable and a synchronous set/reset to a configured value. The four outputs then go to the switch matrix.

---
 rtl/mux8lut_out_pipe_pkg.sv | 27 ++
 rtl/mux8lut_out_pipe_lane.sv | 87 ++++++++
 rtl/mux8lut_out_pipe.sv | 62 ++++++
 tb/tb_mux8lut_out_pipe.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mux8lut_out_pipe_pkg.sv
// mux8lut_out_pipe_pkg
// Shared constants for the MUX8LUT output register stage: per-lane depth
// encoding, ConfigBits field positions and the lane count.
package mux8lut_out_pipe_pkg;

  // Lane output depth select. Code 2'b11 is reserved and decodes as DEPTH_TWO.
  typedef enum logic [1:0] {
    DEPTH_BYPASS = 2'b00,
    DEPTH_ONE    = 2'b01,
    DEPTH_TWO    = 2'b10,
    DEPTH_RSVD   = 2'b11
  } depth_e;

  localparam int unsigned LANES = 4;

  // Depth field LSB positions inside ConfigBits, lane order AB, AD, AH, EF.
  localparam int unsigned AB_DEPTH_LSB = 0;
  localparam int unsigned AD_DEPTH_LSB = 2;
  localparam int unsigned AH_DEPTH_LSB = 4;
  localparam int unsigned EF_DEPTH_LSB = 6;
  localparam int unsigned DEPTH_LSB [LANES] = '{AB_DEPTH_LSB, AD_DEPTH_LSB,
                                                AH_DEPTH_LSB, EF_DEPTH_LSB};

  localparam int unsigned SRVAL_BIT  = 8;
  localparam int unsigned CE_USE_BIT = 9;

endpackage

// File: rtl/mux8lut_out_pipe_lane.sv
// mux8out_pipe_lane
// One lane of the MUX8LUT output register stage: two flops (s1, s2) that
// always advance on an enabled edge, plus a depth-selected output mux.
// Optional feature macro: MUX8OUT_SYNC_SR_EN enables the synchronous
// set/reset to srval; without it sr and srval are ignored.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset, clears s1/s2
//   d      - lane input
//   ena    - effective clock enable
//   sr     - synchronous set/reset request (only with MUX8OUT_SYNC_SR_EN)
//   srval  - value loaded by sr
//   depth  - output select: bypass, s1 or s2
//   q      - lane output
//
// cus_mux21
// 2:1 mux cell matching the one used by the upstream MUX8LUT stage.
//   A0 - selected when S=0, A1 - selected when S=1, X - output
module cus_mux21 (
  input  logic A0,
  input  logic A1,
  input  logic S,
  output logic X
);
  assign X = S ? A1 : A0;
endmodule

module mux8out_pipe_lane
  import mux8lut_out_pipe_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   d,
  input  logic   ena,
  input  logic   sr,
  input  logic   srval,
  input  depth_e depth,
  output logic   q
);

  logic       s1;
  logic       s2;
  logic       q_lo;
  logic [1:0] depth_bits;

  assign depth_bits = depth;

`ifndef MUX8OUT_SYNC_SR_EN
  logic unused_sr;
  assign unused_sr = &{1'b0, sr, srval};
`endif

  // Flops advance independently of depth so a depth change exposes
  // already-pipelined data without a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end
`ifdef MUX8OUT_SYNC_SR_EN
    else if (sr) begin
      s1 <= srval;
      s2 <= srval;
    end
`endif
    else if (ena) begin
      s1 <= d;
      s2 <= s1;
    end
  end

  // depth[0] picks d/s1, depth[1] overrides with s2 (so reserved 11 acts as 10).
  cus_mux21 u_mux_lo (
    .A0 (d),
    .A1 (s1),
    .S  (depth_bits[0]),
    .X  (q_lo)
  );

  cus_mux21 u_mux_hi (
    .A0 (q_lo),
    .A1 (s2),
    .S  (depth_bits[1]),
    .X  (q)
  );

endmodule

// File: rtl/mux8lut_out_pipe.sv
// mux8lut_out_pipe
// Configurable output register stage downstream of the MUX8LUT
// wide-function mux in the LUT4AB tile. Each of the four mux results is
// bypassed or delayed by one or two registered stages before going to the
// switch matrix. Optional feature macro: MUX8OUT_SYNC_SR_EN (sync set/reset).
// Ports:
//   UserCLK    - fabric user clock
//   RESETn     - asynchronous active-low reset of all stage flops
//   M_AB/AD/AH/EF - mux results from the upstream stage
//   CE         - shared clock enable, honoured when ConfigBits[9]=1
//   SR         - shared synchronous set/reset request
//   Q_AB/AD/AH/EF - lane outputs to the switch matrix
//   ConfigBits - [7:0] lane depths (2 bits each, AB lowest), [8] SRVAL,
//                [9] CE_USE
module mux8lut_out_pipe
  import mux8lut_out_pipe_pkg::*;
#(
  parameter int unsigned NoConfigBits = 10
) (
  input  logic                    UserCLK,
  input  logic                    RESETn,
  input  logic                    M_AB,
  input  logic                    M_AD,
  input  logic                    M_AH,
  input  logic                    M_EF,
  input  logic                    CE,
  input  logic                    SR,
  output logic                    Q_AB,
  output logic                    Q_AD,
  output logic                    Q_AH,
  output logic                    Q_EF,
  input  logic [NoConfigBits-1:0] ConfigBits
);

  logic [LANES-1:0] m_in;
  logic [LANES-1:0] q_out;
  logic             ena;
  logic             srval;

  assign m_in  = {M_EF, M_AH, M_AD, M_AB};
  assign ena   = ConfigBits[CE_USE_BIT] ? CE : 1'b1;
  assign srval = ConfigBits[SRVAL_BIT];

  assign Q_AB = q_out[0];
  assign Q_AD = q_out[1];
  assign Q_AH = q_out[2];
  assign Q_EF = q_out[3];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mux8out_pipe_lane u_lane (
      .clk   (UserCLK),
      .rst_n (RESETn),
      .d     (m_in[i]),
      .ena   (ena),
      .sr    (SR),
      .srval (srval),
      .depth (depth_e'(ConfigBits[DEPTH_LSB[i] +: 2])),
      .q     (q_out[i])
    );
  end

endmodule

// File: tb/tb_mux8lut_out_pipe.sv
module tb_mux8lut_out_pipe;

  logic       clk;
  logic       rst_n;
  logic [3:0] m;
  logic       ce;
  logic       sr;
  logic [9:0] cfg;
  logic       q_ab, q_ad, q_ah, q_ef;
  logic [3:0] q;

  int checks;
  int failures;

  typedef struct {
    logic [9:0] cfg;
    logic [3:0] m;
    logic       ce;
    logic [3:0] exp_q;
    string      name;
  } vec_t;

  vec_t vecs[$];

  assign q = {q_ef, q_ah, q_ad, q_ab};

  mux8lut_out_pipe #(.NoConfigBits(10)) dut (
    .UserCLK    (clk),
    .RESETn     (rst_n),
    .M_AB       (m[0]),
    .M_AD       (m[1]),
    .M_AH       (m[2]),
    .M_EF       (m[3]),
    .CE         (ce),
    .SR         (sr),
    .Q_AB       (q_ab),
    .Q_AD       (q_ad),
    .Q_AH       (q_ah),
    .Q_EF       (q_ef),
    .ConfigBits (cfg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no summary expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic add(input logic [9:0] c, input logic [3:0] mi, input logic cei,
                     input logic [3:0] e, input string n);
    vec_t v;
    v.cfg = c; v.m = mi; v.ce = cei; v.exp_q = e; v.name = n;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Depth mix AB=00 AD=01 AH=10 EF=11; pattern 1,0,1,1 then flush.
    // Each vector is checked mid-cycle, before the edge that samples it.
    add(10'h0E4, 4'b1111, 1'b0, 4'b0001, "lat1");
    add(10'h0E4, 4'b0000, 1'b0, 4'b0010, "lat2");
    add(10'h0E4, 4'b1111, 1'b0, 4'b1101, "lat3");
    add(10'h0E4, 4'b1111, 1'b0, 4'b0011, "lat4");
    add(10'h0E4, 4'b0000, 1'b0, 4'b1110, "lat5");
    add(10'h0E4, 4'b0000, 1'b0, 4'b1100, "lat6");
    add(10'h0E4, 4'b0000, 1'b0, 4'b0000, "lat7");
    // CE_USE=1, all depth 10, toggling input, CE low for 3 cycles.
    add(10'h2AA, 4'b1111, 1'b1, 4'b0000, "ce1");
    add(10'h2AA, 4'b0000, 1'b1, 4'b0000, "ce2");
    add(10'h2AA, 4'b1111, 1'b0, 4'b1111, "ce3");
    add(10'h2AA, 4'b0000, 1'b0, 4'b1111, "ce4");
    add(10'h2AA, 4'b1111, 1'b0, 4'b1111, "ce5");
    add(10'h2AA, 4'b0000, 1'b1, 4'b1111, "ce6");
    add(10'h2AA, 4'b1111, 1'b1, 4'b0000, "ce7");
    add(10'h2AA, 4'b0000, 1'b1, 4'b0000, "ce8");
    add(10'h2AA, 4'b0000, 1'b1, 4'b1111, "ce9");
    add(10'h2AA, 4'b0000, 1'b1, 4'b0000, "ce10");
    // CE_USE=0 with CE held low: data flows every cycle.
    add(10'h0AA, 4'b1111, 1'b0, 4'b0000, "nce1");
    add(10'h0AA, 4'b0000, 1'b0, 4'b0000, "nce2");
    add(10'h0AA, 4'b1111, 1'b0, 4'b1111, "nce3");
    add(10'h0AA, 4'b0000, 1'b0, 4'b0000, "nce4");
    add(10'h0AA, 4'b0000, 1'b0, 4'b1111, "nce5");
    add(10'h0AA, 4'b0000, 1'b0, 4'b0000, "nce6");
    // All depth 01, distinct per-lane data.
    add(10'h055, 4'b1010, 1'b0, 4'b0000, "ind1");
    add(10'h055, 4'b0101, 1'b0, 4'b1010, "ind2");
    add(10'h055, 4'b0000, 1'b0, 4'b0101, "ind3");

    // Reset with depth 01 and inputs high.
    rst_n = 1'b0; cfg = 10'h055; m = 4'b1111; ce = 1'b0; sr = 1'b0;
    repeat (3) tick();
    check("reset_q", q, 4'b0000);
    #3 rst_n = 1'b1;
    m = 4'b0001;
    tick();
    check("first_capture", q, 4'b0001);
    m = 4'b0000;
    repeat (2) tick();
    check("flushed", q, 4'b0000);

    foreach (vecs[i]) begin
      cfg = vecs[i].cfg;
      m   = vecs[i].m;
      ce  = vecs[i].ce;
      #2;
      check(vecs[i].name, q, vecs[i].exp_q);
      tick();
    end

`ifdef MUX8OUT_SYNC_SR_EN
    // SRVAL=1 into a 0-filled pipe with CE low.
    cfg = 10'h3AA; m = 4'b0000; ce = 1'b1;
    repeat (2) tick();
    check("sr_pre0", q, 4'b0000);
    ce = 1'b0; sr = 1'b1;
    tick();
    sr = 1'b0;
    check("sr_set1", q, 4'b1111);
    tick();
    check("sr_hold1", q, 4'b1111);
    // SRVAL=0 into a 1-filled pipe, SR and CE together.
    cfg = 10'h2AA; m = 4'b1111; ce = 1'b1;
    repeat (2) tick();
    check("sr_pre1", q, 4'b1111);
    sr = 1'b1;
    tick();
    sr = 1'b0;
    check("sr_clr0", q, 4'b0000);
`else
    // SR ignored: pipe of 1s keeps flowing.
    cfg = 10'h2AA; m = 4'b1111; ce = 1'b1;
    repeat (2) tick();
    check("nosr_pre1", q, 4'b1111);
    sr = 1'b1; m = 4'b0000;
    tick();
    sr = 1'b0;
    check("nosr_hold", q, 4'b1111);
    tick();
    check("nosr_flow", q, 4'b0000);
`endif

    // Async reset mid-stream: AH depth 10, others bypass.
    cfg = 10'h020; m = 4'b1111; ce = 1'b0; sr = 1'b0;
    repeat (2) tick();
    check("ah_full", q, 4'b1111);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", q, 4'b1011);
    m = 4'b0100;
    #1;
    check("bypass_in_rst", q, 4'b0000);
    m = 4'b1010;
    #1;
    check("bypass_in_rst2", q, 4'b1010);
    tick();
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
